// File: rtl/synth_bus_pkg.sv
// Shared types and helpers for the register-bus arbiter.
// - bus_state_t : arbiter FSM states
// - PRIO_FIXED / PRIO_RR : arbitration mode selectors
// - onehot_bank() : bank index to one-hot select, zero when the bank is unmapped
package synth_bus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} bus_state_t;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Widest bank select the helper can produce; callers truncate to their bank count.
  localparam int unsigned MAX_BANKS = 32;

  function automatic logic [MAX_BANKS-1:0] onehot_bank(input int unsigned bank,
                                                       input int unsigned num_banks);
    logic [MAX_BANKS-1:0] sel;
    sel = '0;
    if (bank < num_banks && bank < MAX_BANKS) begin
      sel = MAX_BANKS'(1) << bank;
    end
    return sel;
  endfunction

endpackage

// File: rtl/synth_rr_arbiter.sv
// Combinational grant selection for the register-bus arbiter.
// Ports:
//   req         in  per-master request vector
//   ptr         in  round-robin start index (ignored in fixed mode)
//   grant_valid out at least one request is set
//   grant_idx   out index of the winning master
// Fixed mode: lowest set index wins. Round-robin mode: first set index at or after ptr,
// wrapping from NUM_MASTERS-1 back to 0.
module synth_rr_arbiter
  import synth_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned PRIO_MODE   = PRIO_FIXED,
  parameter int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  always_comb begin
    int unsigned start_idx;
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    start_idx   = (PRIO_MODE == PRIO_RR) ? 32'(ptr) : 32'd0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = (start_idx + i) % NUM_MASTERS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/synth_param_bus_arbiter.sv
// Arbitrates NUM_MASTERS register-bus masters onto the engine control bus (reg_clk domain).
// Ports:
//   reg_clk, reset_reg     clock and synchronous active-high reset
//   m_req/m_we/m_addr/m_wdata  per-master request, direction, {bank,offset}, write data
//   m_ack, m_rdata, m_err  completion pulse to winner, read data, unmapped-bank flag
//   eng_adr, eng_bank_sel, eng_wdata  offset, one-hot bank select, write data to engine
//   eng_write, eng_read    one-cycle engine strobes
//   eng_rdata              engine read data, valid READ_LAT cycles after the read strobe cycle
//   busy                   high whenever a transaction is in flight
// All outputs decode registered state only, so there is no path from m_* to eng_*.
module synth_param_bus_arbiter
  import synth_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned OFS_WIDTH   = 7,
  parameter int unsigned BANK_BITS   = 3,
  parameter int unsigned NUM_BANKS   = 6,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned PRIO_MODE   = PRIO_FIXED
) (
  input  logic                              reg_clk,
  input  logic                              reset_reg,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*(BANK_BITS+OFS_WIDTH)-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              m_err,
  output logic [OFS_WIDTH-1:0]              eng_adr,
  output logic [NUM_BANKS-1:0]              eng_bank_sel,
  output logic                              eng_write,
  output logic                              eng_read,
  output logic [DATA_WIDTH-1:0]             eng_wdata,
  input  logic [DATA_WIDTH-1:0]             eng_rdata,
  output logic                              busy
);

  localparam int unsigned ADDR_W = BANK_BITS + OFS_WIDTH;
  localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Counter only ever holds READ_LAT-1 down to 0.
  localparam int unsigned CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  bus_state_t state_q, state_d;

  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      winner_q;
  logic                  we_q;
  logic                  mapped_q;
  logic [OFS_WIDTH-1:0]  ofs_q;
  logic [NUM_BANKS-1:0]  bank_sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_idx;
  logic [ADDR_W-1:0]     sel_addr;
  logic [BANK_BITS-1:0]  sel_bank;
  logic [NUM_BANKS-1:0]  sel_bank_oh;
  logic [DATA_WIDTH-1:0] sel_wdata;

  synth_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .PRIO_MODE   (PRIO_MODE),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req         (m_req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Winner's request fields, muxed out of the packed master buses.
  always_comb begin
    sel_addr    = m_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata   = m_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_bank    = sel_addr[ADDR_W-1 -: BANK_BITS];
    sel_bank_oh = NUM_BANKS'(onehot_bank(32'(sel_bank), NUM_BANKS));
  end

  // State register.
  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches, latency counter, read capture and round-robin pointer.
  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      ptr_q      <= '0;
      winner_q   <= '0;
      we_q       <= 1'b0;
      mapped_q   <= 1'b0;
      ofs_q      <= '0;
      bank_sel_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            winner_q   <= grant_idx;
            we_q       <= m_we[grant_idx];
            mapped_q   <= (32'(sel_bank) < NUM_BANKS);
            ofs_q      <= sel_addr[OFS_WIDTH-1:0];
            bank_sel_q <= sel_bank_oh;
            wdata_q    <= sel_wdata;
          end
        end
        ISSUE: cnt_q <= CNT_W'(READ_LAT - 1);
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= eng_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          ptr_q <= (32'(winner_q) == NUM_MASTERS - 1) ? '0 : winner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: pure decode of registered state.
  always_comb begin
    m_ack        = '0;
    m_rdata      = '0;
    m_err        = 1'b0;
    eng_adr      = '0;
    eng_bank_sel = '0;
    eng_wdata    = '0;
    eng_write    = 1'b0;
    eng_read     = 1'b0;
    busy         = (state_q != IDLE);
    if (state_q != IDLE) begin
      eng_adr      = ofs_q;
      eng_bank_sel = bank_sel_q;
      eng_wdata    = wdata_q;
    end
    // Unmapped banks complete with normal timing but never strobe the engine.
    if (state_q == ISSUE && mapped_q) begin
      eng_write = we_q;
      eng_read  = !we_q;
    end
    if (state_q == DONE) begin
      m_ack[winner_q] = 1'b1;
      m_err           = !mapped_q;
      if (!we_q && mapped_q) begin
        m_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_synth_param_bus_arbiter.sv
module tb_synth_param_bus_arbiter;

  localparam int READ_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Fixed-priority instance, two masters.
  logic [1:0]  f_req = '0, f_we = '0, f_ack;
  logic [19:0] f_addr = '0;
  logic [15:0] f_wdata = '0;
  logic [7:0]  f_rdata, f_ewd, f_erd = '0;
  logic        f_err, f_wr, f_rd, f_busy;
  logic [6:0]  f_adr;
  logic [5:0]  f_sel;

  // Round-robin instance, three masters.
  logic [2:0]  r_req = '0, r_we = '0, r_ack;
  logic [29:0] r_addr = '0;
  logic [23:0] r_wdata = '0;
  logic [7:0]  r_rdata, r_ewd, r_erd = '0;
  logic        r_err, r_wr, r_rd, r_busy;
  logic [6:0]  r_adr;
  logic [5:0]  r_sel;

  synth_param_bus_arbiter #(.NUM_MASTERS(2), .READ_LAT(READ_LAT), .PRIO_MODE(0)) dut_f (
    .reg_clk(clk), .reset_reg(rst), .m_req(f_req), .m_we(f_we), .m_addr(f_addr),
    .m_wdata(f_wdata), .m_ack(f_ack), .m_rdata(f_rdata), .m_err(f_err), .eng_adr(f_adr),
    .eng_bank_sel(f_sel), .eng_write(f_wr), .eng_read(f_rd), .eng_wdata(f_ewd),
    .eng_rdata(f_erd), .busy(f_busy)
  );

  synth_param_bus_arbiter #(.NUM_MASTERS(3), .READ_LAT(READ_LAT), .PRIO_MODE(1)) dut_r (
    .reg_clk(clk), .reset_reg(rst), .m_req(r_req), .m_we(r_we), .m_addr(r_addr),
    .m_wdata(r_wdata), .m_ack(r_ack), .m_rdata(r_rdata), .m_err(r_err), .eng_adr(r_adr),
    .eng_bank_sel(r_sel), .eng_write(r_wr), .eng_read(r_rd), .eng_wdata(r_ewd),
    .eng_rdata(r_erd), .busy(r_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Observations from one fixed-instance transaction (cycle k counted from request cycle T).
  int         obs_ack_cyc, obs_stb_cyc, obs_wr_n, obs_rd_n;
  logic [1:0] obs_ack_bits;
  logic [7:0] obs_rdata, obs_ewd;
  logic       obs_err, obs_stable, obs_extra;
  logic [5:0] obs_sel;
  logic [6:0] obs_adr;

  // Round-robin reference: pointer starts at 0 after reset.
  int rr_ptr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the fixed instance from an IDLE cycle and records what happens.
  task automatic txn_f(input int m, input bit we, input logic [2:0] bank, input logic [6:0] ofs,
                       input logic [7:0] wd, input logic [7:0] rd_val);
    obs_ack_cyc = -1; obs_stb_cyc = -1; obs_wr_n = 0; obs_rd_n = 0; obs_ack_bits = '0;
    obs_rdata = '0; obs_err = 1'b0; obs_stable = 1'b1; obs_extra = 1'b0;
    obs_sel = '0; obs_adr = '0; obs_ewd = '0;
    f_we[m] = we;
    f_addr[m*10 +: 10] = {bank, ofs};
    f_wdata[m*8 +: 8] = wd;
    f_req[m] = 1'b1;
    for (int k = 1; k <= 12 && obs_ack_cyc < 0; k++) begin
      step();
      f_erd = (k == 1 + READ_LAT) ? rd_val : 8'($urandom);
      if (k == 1) begin
        obs_sel = f_sel; obs_adr = f_adr; obs_ewd = f_ewd;
      end else if (f_sel !== obs_sel || f_adr !== obs_adr || f_ewd !== obs_ewd) begin
        obs_stable = 1'b0;
      end
      if (f_wr) begin obs_wr_n++; obs_stb_cyc = k; end
      if (f_rd) begin obs_rd_n++; obs_stb_cyc = k; end
      if (f_ack != '0) begin
        obs_ack_cyc = k; obs_ack_bits = f_ack; obs_rdata = f_rdata; obs_err = f_err;
        f_req[m] = 1'b0;
      end
    end
    f_req[m] = 1'b0;
    step();
    if (f_ack != '0 || f_wr || f_rd || f_busy) obs_extra = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_vec++;
    if ({f_ack, f_rdata, f_err, f_adr, f_sel, f_wr, f_rd, f_ewd, f_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_f: outputs %h expected 0",
               {f_ack, f_rdata, f_err, f_adr, f_sel, f_wr, f_rd, f_ewd, f_busy});
    end
    n_vec++;
    if ({r_ack, r_rdata, r_err, r_adr, r_sel, r_wr, r_rd, r_ewd, r_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_r: outputs %h expected 0",
               {r_ack, r_rdata, r_err, r_adr, r_sel, r_wr, r_rd, r_ewd, r_busy});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed_write();
    txn_f(1, 1'b1, 3'd2, 7'h15, 8'hA5, 8'h00);
    n_vec++;
    if (obs_sel !== 6'b000100) begin n_err++; $display("FAIL wr_sel: got %b expected 000100", obs_sel); end
    n_vec++;
    if (obs_adr !== 7'h15) begin n_err++; $display("FAIL wr_adr: got %h expected 15", obs_adr); end
    n_vec++;
    if (obs_ewd !== 8'hA5) begin n_err++; $display("FAIL wr_wdata: got %h expected a5", obs_ewd); end
    n_vec++;
    if (obs_wr_n != 1 || obs_rd_n != 0 || obs_stb_cyc != 1) begin
      n_err++;
      $display("FAIL wr_strobe: writes %0d reads %0d at T+%0d expected 1 write at T+1",
               obs_wr_n, obs_rd_n, obs_stb_cyc);
    end
    n_vec++;
    if (obs_ack_cyc != 2 || obs_ack_bits !== 2'b10) begin
      n_err++;
      $display("FAIL wr_ack: %b at T+%0d expected 10 at T+2", obs_ack_bits, obs_ack_cyc);
    end
    n_vec++;
    if (obs_stable !== 1'b1 || obs_extra !== 1'b0) begin
      n_err++;
      $display("FAIL wr_hold: stable %b extra %b expected 1 0", obs_stable, obs_extra);
    end
  endtask

  task automatic test_read();
    txn_f(0, 1'b0, 3'd1, 7'h22, 8'h00, 8'h3C);
    n_vec++;
    if (obs_rd_n != 1 || obs_wr_n != 0 || obs_stb_cyc != 1) begin
      n_err++;
      $display("FAIL rd_strobe: reads %0d writes %0d at T+%0d expected 1 read at T+1",
               obs_rd_n, obs_wr_n, obs_stb_cyc);
    end
    n_vec++;
    if (obs_ack_cyc != 2 + READ_LAT || obs_ack_bits !== 2'b01) begin
      n_err++;
      $display("FAIL rd_ack: %b at T+%0d expected 01 at T+%0d", obs_ack_bits, obs_ack_cyc,
               2 + READ_LAT);
    end
    n_vec++;
    if (obs_rdata !== 8'h3C || obs_err !== 1'b0) begin
      n_err++;
      $display("FAIL rd_data: got %h err %b expected 3c err 0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_unmapped();
    txn_f(0, 1'b0, 3'd7, 7'h05, 8'h00, 8'h77);
    n_vec++;
    if (obs_rd_n + obs_wr_n != 0 || obs_sel !== 6'b0) begin
      n_err++;
      $display("FAIL unmapped_strobe: strobes %0d sel %b expected 0 0", obs_rd_n + obs_wr_n,
               obs_sel);
    end
    n_vec++;
    if (obs_ack_cyc != 2 + READ_LAT || obs_rdata !== 8'h00 || obs_err !== 1'b1) begin
      n_err++;
      $display("FAIL unmapped_ack: T+%0d data %h err %b expected T+%0d 00 1", obs_ack_cyc,
               obs_rdata, obs_err, 2 + READ_LAT);
    end
  endtask

  // Random single transactions against rules: ack timing, strobe count, data, error.
  task automatic test_random_fixed();
    for (int i = 0; i < 24; i++) begin
      int         m   = $urandom_range(0, 1);
      bit         we  = 1'($urandom);
      logic [2:0] bk  = 3'($urandom);
      logic [6:0] ofs = 7'($urandom);
      logic [7:0] wd  = 8'($urandom);
      logic [7:0] rv  = 8'($urandom);
      bit         mapped = (bk < 3'd6);
      int         exp_ack = we ? 2 : 2 + READ_LAT;
      logic [5:0] exp_sel = mapped ? 6'(1 << bk) : 6'b0;
      logic [7:0] exp_rd  = (!we && mapped) ? rv : 8'h00;
      int         exp_stb = mapped ? 1 : 0;
      txn_f(m, we, bk, ofs, wd, rv);
      n_vec++;
      if (obs_ack_cyc != exp_ack || obs_ack_bits !== 2'(1 << m) || obs_extra) begin
        n_err++;
        $display("FAIL rand_ack[%0d]: %b at T+%0d extra %b expected %b at T+%0d", i,
                 obs_ack_bits, obs_ack_cyc, obs_extra, 2'(1 << m), exp_ack);
      end
      n_vec++;
      if (obs_sel !== exp_sel || obs_adr !== ofs ||
          (we ? obs_wr_n : obs_rd_n) != exp_stb || (we ? obs_rd_n : obs_wr_n) != 0) begin
        n_err++;
        $display("FAIL rand_bus[%0d]: sel %b adr %h wr %0d rd %0d expected sel %b adr %h %0d %s",
                 i, obs_sel, obs_adr, obs_wr_n, obs_rd_n, exp_sel, ofs, exp_stb,
                 we ? "write" : "read");
      end
      n_vec++;
      if (obs_rdata !== exp_rd || obs_err !== !mapped) begin
        n_err++;
        $display("FAIL rand_data[%0d]: data %h err %b expected %h %b", i, obs_rdata, obs_err,
                 exp_rd, !mapped);
      end
    end
  endtask

  task automatic test_simultaneous_fixed();
    int order[$];
    int cyc[$];
    f_we = 2'b11;
    f_req = 2'b11;
    for (int k = 1; k <= 15 && order.size() < 2; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (f_ack[i]) begin order.push_back(i); cyc.push_back(k); f_req[i] = 1'b0; end
      end
    end
    f_req = 2'b00;
    step();
    n_vec++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1 || cyc[0] != 2 || cyc[1] != 5) begin
      n_err++;
      $display("FAIL simul_fixed: %0d acks, first m%0d@%0d second m%0d@%0d expected m0@2 m1@5",
               order.size(), order.size() > 0 ? order[0] : -1, order.size() > 0 ? cyc[0] : -1,
               order.size() > 1 ? order[1] : -1, order.size() > 1 ? cyc[1] : -1);
    end
  endtask

  // Reference round-robin choice over a request mask.
  function automatic int rr_pick(input logic [2:0] mask);
    for (int i = 0; i < 3; i++) begin
      if (mask[(rr_ptr + i) % 3]) return (rr_ptr + i) % 3;
    end
    return -1;
  endfunction

  // Waits for one ack on the round-robin instance; returns the acked index or -1.
  task automatic wait_ack_r(output int who);
    who = -1;
    for (int k = 0; k < 12 && who < 0; k++) begin
      step();
      for (int i = 0; i < 3; i++) if (r_ack[i]) who = i;
    end
  endtask

  task automatic test_rr_order();
    int who;
    int exp;
    r_we = 3'b111;
    r_req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_ack_r(who);
      exp = rr_pick(3'b111);
      rr_ptr = (exp + 1) % 3;
      if (n == 3) r_req = 3'b000;
      n_vec++;
      if (who != exp) begin
        n_err++;
        $display("FAIL rr_order[%0d]: granted m%0d expected m%0d", n, who, exp);
      end
    end
    step();
  endtask

  task automatic test_rr_random();
    int who;
    int exp;
    for (int n = 0; n < 16; n++) begin
      logic [2:0] mask = 3'($urandom_range(1, 7));
      r_req = mask;
      wait_ack_r(who);
      r_req = 3'b000;
      exp = rr_pick(mask);
      rr_ptr = (exp + 1) % 3;
      step();
      n_vec++;
      if (who != exp) begin
        n_err++;
        $display("FAIL rr_rand[%0d]: mask %b granted m%0d expected m%0d", n, mask, who, exp);
      end
    end
  endtask

  task automatic test_reset_wait();
    int bad = 0;
    f_we[0] = 1'b0;
    f_addr[9:0] = {3'd1, 7'h40};
    f_req[0] = 1'b1;
    step();               // ISSUE
    step();               // WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    f_req = 2'b00;
    n_vec++;
    if ({f_ack, f_rdata, f_err, f_adr, f_sel, f_wr, f_rd, f_ewd, f_busy} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_outputs: %h expected 0",
               {f_ack, f_rdata, f_err, f_adr, f_sel, f_wr, f_rd, f_ewd, f_busy});
    end
    for (int k = 0; k < 6; k++) begin
      step();
      if (f_ack != '0 || f_wr || f_rd) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL rst_wait_quiet: %0d active cycles expected 0", bad); end
    txn_f(0, 1'b1, 3'd4, 7'h11, 8'h5A, 8'h00);
    n_vec++;
    if (obs_ack_cyc != 2 || obs_ack_bits !== 2'b01 || obs_sel !== 6'b010000 || obs_wr_n != 1) begin
      n_err++;
      $display("FAIL rst_wait_next: ack %b@T+%0d sel %b writes %0d expected 01@T+2 010000 1",
               obs_ack_bits, obs_ack_cyc, obs_sel, obs_wr_n);
    end
  endtask

  task automatic test_back_to_back();
    int  acks[$];
    int  writes = 0;
    bit  dbl = 1'b0;
    bit  prev = 1'b0;
    f_we[0] = 1'b1;
    f_addr[9:0] = {3'd0, 7'h33};
    f_wdata[7:0] = 8'hC3;
    f_req[0] = 1'b1;
    for (int k = 1; k <= 20 && acks.size() < 3; k++) begin
      step();
      if (f_wr && prev) dbl = 1'b1;
      prev = f_wr;
      if (f_wr) writes++;
      if (f_ack[0]) begin
        acks.push_back(k);
        if (acks.size() == 3) f_req[0] = 1'b0;
      end
    end
    f_req[0] = 1'b0;
    step();
    n_vec++;
    if (acks.size() != 3 || acks[0] != 2 || acks[1] != 5 || acks[2] != 8) begin
      n_err++;
      $display("FAIL b2b_spacing: %0d acks at %0d,%0d,%0d expected 2,5,8", acks.size(),
               acks.size() > 0 ? acks[0] : -1, acks.size() > 1 ? acks[1] : -1,
               acks.size() > 2 ? acks[2] : -1);
    end
    n_vec++;
    if (dbl || writes != 3) begin
      n_err++;
      $display("FAIL b2b_strobe: consecutive %b writes %0d expected 0 3", dbl, writes);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_write();
    test_read();
    test_unmapped();
    test_random_fixed();
    test_simultaneous_fixed();
    test_rr_order();
    test_rr_random();
    test_reset_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
